// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU request issuer:
//   - opcode encodings presented on req_op / alu_op
//   - issuer state encoding
//   - canonical quiet NaN returned for reserved opcodes
//   - bit positions inside the 5-bit response flag word {err,nan,inf,zero,sign}
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcodes. Any value with bit 2 set is reserved and never reaches the ALU.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam int FLAG_W    = 5;
  localparam int FLAG_SIGN = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_NAN  = 3;
  localparam int FLAG_ERR  = 4;

  // Flags reported for a reserved opcode: error plus NaN.
  localparam logic [FLAG_W-1:0] RSVD_FLAGS =
    FLAG_W'((1 << FLAG_ERR) | (1 << FLAG_NAN));

  function automatic logic op_is_reserved(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/fp_classify.sv
// -----------------------------------------------------------------------------
// fp_classify
// Purely combinational IEEE-754 single-precision classifier.
//   value_i : 32-bit word to classify
//   nan_o   : exponent all ones, fraction non-zero
//   inf_o   : exponent all ones, fraction zero
//   zero_o  : exponent zero, fraction zero (either sign)
//   sign_o  : bit 31
// -----------------------------------------------------------------------------
module fp_classify (
  input  logic [31:0] value_i,
  output logic        nan_o,
  output logic        inf_o,
  output logic        zero_o,
  output logic        sign_o
);

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;

  assign exp_ones  = &value_i[30:23];
  assign exp_zero  = ~|value_i[30:23];
  assign frac_zero = ~|value_i[22:0];

  assign nan_o  = exp_ones & ~frac_zero;
  assign inf_o  = exp_ones &  frac_zero;
  assign zero_o = exp_zero &  frac_zero;
  assign sign_o = value_i[31];

endmodule

// File: rtl/alu_issuer.sv
// -----------------------------------------------------------------------------
// alu_issuer
// Accepts one floating-point request at a time, holds its operands on the
// ALU inputs for LATENCY clock edges, captures the ALU result and presents it
// with classification flags on a valid/ready response port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_a, req_b, req_op       request operands and opcode
//   alu_a, alu_b, alu_op       registered operands to the fixed-latency ALU
//   alu_o                      ALU result, sampled on the capture edge only
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_flags,rsp_op captured result, {err,nan,inf,zero,sign}, opcode
//
// LATENCY must lie in 1..15 (the wait counter is 4 bits wide).
// -----------------------------------------------------------------------------
module alu_issuer
  import alu_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_o,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_flags,
  output logic [2:0]  rsp_op
);

  // The counter starts at 0 on the edge after acceptance, so the edge on
  // which it reads LATENCY-1 is the LATENCY-th edge after the operands settled.
  localparam logic [3:0] CAPTURE_CNT = 4'(LATENCY - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              run_q;   // low through reset and until the first edge after it
  logic [31:0]       alu_a_q;
  logic [31:0]       alu_b_q;
  logic [2:0]        alu_op_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic [2:0]        rsp_op_q;

  logic              accept;
  logic              cls_nan;
  logic              cls_inf;
  logic              cls_zero;
  logic              cls_sign;
  logic [FLAG_W-1:0] flags_d;

  fp_classify u_classify (
    .value_i (alu_o),
    .nan_o   (cls_nan),
    .inf_o   (cls_inf),
    .zero_o  (cls_zero),
    .sign_o  (cls_sign)
  );

  always_comb begin
    flags_d            = '0;
    flags_d[FLAG_NAN]  = cls_nan;
    flags_d[FLAG_INF]  = cls_inf;
    flags_d[FLAG_ZERO] = cls_zero;
    flags_d[FLAG_SIGN] = cls_sign;
  end

  // Ready in DONE only when the current response leaves on the same edge,
  // which gives the zero-bubble hand-over between consecutive requests.
  assign req_ready = run_q & ((state_q == ST_IDLE) |
                              ((state_q == ST_DONE) & rsp_ready));
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_op_q    <= '0;
    end else begin
      run_q <= 1'b1;

      case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CAPTURE_CNT) begin
            rsp_data_q  <= alu_o;
            rsp_flags_q <= flags_d;
            rsp_op_q    <= alu_op_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Placed last so a new request overrides the DONE -> IDLE exit above.
      if (accept) begin
        alu_a_q  <= req_a;
        alu_b_q  <= req_b;
        alu_op_q <= req_op;
        cnt_q    <= '0;
        if (op_is_reserved(req_op)) begin
          rsp_data_q  <= CANON_NAN;
          rsp_flags_q <= RSVD_FLAGS;
          rsp_op_q    <= req_op;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end else begin
          state_q <= ST_WAIT;
        end
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_op    = rsp_op_q;

endmodule

// File: tb/tb_alu_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_issuer
// Self-checking bench for alu_issuer. A fixed-latency ALU stand-in drives the
// correct result on alu_o only during the cycle before the expected capture
// edge and random junk otherwise. Expected responses come from a reference
// model built on the ALU function and the IEEE-754 classification rules.
// -----------------------------------------------------------------------------
module tb_alu_issuer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_op = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_o = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_flags;
  logic [2:0]  rsp_op;

  int total = 0;
  int bad   = 0;

  alu_issuer #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_o     (alu_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_op    (rsp_op)
  );

  always #5 clk = ~clk;

  // ALU behaviour: the two directed cases give their true IEEE results,
  // b == 0 passes a through (handy for special values), else a mixing hash.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    if (op == 3'b000 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 3'b011 && a == 32'h40400000 && b == 32'hC0000000) return 32'hC0C00000;
    if (b == 32'h0) return a;
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
  endfunction

  // Reference response: {flags, data}.
  function automatic logic [36:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [31:0] w;
    int unsigned e, fr;
    logic nan, inf, zero;
    if (op >= 3'd4) return {5'b11000, 32'h7FC00000};
    w    = alu_fn(a, b, op);
    e    = (w >> 23) & 32'hFF;
    fr   = w % (1 << 23);
    nan  = (e == 255) && (fr != 0);
    inf  = (e == 255) && (fr == 0);
    zero = (e == 0) && (fr == 0);
    return {1'b0, nan, inf, zero, w[31], w};
  endfunction

  // ALU stand-in: count edges since the accepting edge; the result is valid
  // only in the cycle leading into the LAT-th edge after acceptance.
  logic acc_next = 1'b0;
  int   age = 1000;
  always @(negedge clk) acc_next = req_valid && req_ready;
  always @(posedge clk) begin
    #1;
    if (acc_next) age = 0;
    else if (age < 1000) age++;
    if (age == LAT - 1 && !alu_op[2]) alu_o = alu_fn(alu_a, alu_b, alu_op);
    else alu_o = $urandom;
  end

  // Drive one request from IDLE and wait for rsp_valid. lat counts the
  // accepting edge as 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output int lat);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [111:0] outs;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs = {alu_a, alu_b, alu_op, rsp_data, rsp_flags, rsp_op, rsp_valid, req_ready};
    total++; if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
    $display("reset done");
  endtask

  task automatic test_add();
    int lat;
    issue(32'h3F800000, 32'h40000000, 3'b000, lat);
    total++; if (lat != LAT + 1) begin bad++; $display("FAIL add_latency got=%0d exp=%0d", lat, LAT + 1); end
    total++; if (rsp_data !== 32'h40400000) begin bad++; $display("FAIL add_data got=%h exp=40400000", rsp_data); end
    total++; if (rsp_flags !== 5'b00000) begin bad++; $display("FAIL add_flags got=%b exp=00000", rsp_flags); end
    total++; if (alu_a !== 32'h3F800000) begin bad++; $display("FAIL add_alu_a_hold got=%h exp=3f800000", alu_a); end
    $display("txn add data=%h flags=%b lat=%0d", rsp_data, rsp_flags, lat);
    finish_rsp();
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL add_after_rsp got=%b exp=01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_mul();
    int lat;
    issue(32'h40400000, 32'hC0000000, 3'b011, lat);
    total++; if (lat != LAT + 1) begin bad++; $display("FAIL mul_latency got=%0d exp=%0d", lat, LAT + 1); end
    total++; if (rsp_data !== 32'hC0C00000) begin bad++; $display("FAIL mul_data got=%h exp=c0c00000", rsp_data); end
    total++; if (rsp_flags !== 5'b00001) begin bad++; $display("FAIL mul_flags got=%b exp=00001", rsp_flags); end
    total++; if (rsp_op !== 3'b011) begin bad++; $display("FAIL mul_op got=%b exp=011", rsp_op); end
    $display("txn mul data=%h flags=%b lat=%0d", rsp_data, rsp_flags, lat);
    finish_rsp();
  endtask

  task automatic test_reserved();
    int lat;
    logic [2:0] op;
    op = 3'(4 + $urandom_range(0, 3));
    issue($urandom, $urandom, op, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL rsvd_latency got=%0d exp=1", lat); end
    total++; if (rsp_data !== 32'h7FC00000) begin bad++; $display("FAIL rsvd_data got=%h exp=7fc00000", rsp_data); end
    total++; if (rsp_flags !== 5'b11000) begin bad++; $display("FAIL rsvd_flags got=%b exp=11000", rsp_flags); end
    total++; if (rsp_op !== op) begin bad++; $display("FAIL rsvd_op got=%b exp=%b", rsp_op, op); end
    $display("txn reserved op=%b data=%h flags=%b", rsp_op, rsp_data, rsp_flags);
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] a, b;
    logic [36:0] exp;
    a = $urandom; b = $urandom | 32'h1;
    exp = ref_rsp(a, b, 3'b010);
    issue(a, b, 3'b010, lat);
    total++; if (lat != LAT + 1) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT + 1); end
    // A new request is offered but must not be taken while the response waits.
    req_a = ~a; req_b = b; req_op = 3'b000; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, req_ready); end
      @(posedge clk); #1;
      total++;
      if ({rsp_valid, rsp_flags, rsp_data} !== {1'b1, exp}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b_%b_%h exp=1_%b_%h", i, rsp_valid, rsp_flags, rsp_data, exp[36:32], exp[31:0]);
      end
      total++; if (alu_a !== a) begin bad++; $display("FAIL bp_alu_a cyc=%0d got=%h exp=%h", i, alu_a, a); end
    end
    req_valid = 1'b0;
    $display("txn backpressure data=%h flags=%b", rsp_data, rsp_flags);
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] a2;
    logic [36:0] exp1, exp2;
    logic [2:0] op3;
    exp1 = ref_rsp(32'h12345678, 32'h9ABCDEF1, 3'b001);
    a2   = 32'h7F800000;        // b = 0 passes infinity through the ALU
    exp2 = ref_rsp(a2, 32'h0, 3'b000);
    req_a = 32'h12345678; req_b = 32'h9ABCDEF1; req_op = 3'b001; req_valid = 1'b1;
    @(posedge clk); #1;
    // Second request offered at once and held; ignored while waiting.
    req_a = a2; req_b = 32'h0; req_op = 3'b000;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_wait_ready got=%b exp=0", req_ready); end
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      total++; if (alu_a !== 32'h12345678) begin bad++; $display("FAIL b2b_wait_alu_a got=%h exp=12345678", alu_a); end
    end
    total++; if (lat != LAT + 1) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, LAT + 1); end
    total++; if ({rsp_flags, rsp_data} !== exp1) begin bad++; $display("FAIL b2b_rsp1 got=%b_%h exp=%b_%h", rsp_flags, rsp_data, exp1[36:32], exp1[31:0]); end
    $display("txn b2b first data=%h flags=%b", rsp_data, rsp_flags);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    total++; if ({rsp_valid, alu_a} !== {1'b0, a2}) begin bad++; $display("FAIL b2b_handover got=%b_%h exp=0_%h", rsp_valid, alu_a, a2); end
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat != LAT + 1) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat, LAT + 1); end
    total++; if ({rsp_flags, rsp_data} !== exp2) begin bad++; $display("FAIL b2b_rsp2 got=%b_%h exp=%b_%h", rsp_flags, rsp_data, exp2[36:32], exp2[31:0]); end
    $display("txn b2b second data=%h flags=%b", rsp_data, rsp_flags);
    // Reserved op handed over in the same edge: response stays valid.
    op3 = 3'b110;
    req_a = $urandom; req_b = $urandom; req_op = op3; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, rsp_flags, rsp_data, rsp_op} !== {1'b1, 5'b11000, 32'h7FC00000, op3}) begin
      bad++; $display("FAIL b2b_rsvd got=%b_%b_%h_%b exp=1_11000_7fc00000_%b", rsp_valid, rsp_flags, rsp_data, rsp_op, op3);
    end
    $display("txn b2b reserved data=%h flags=%b", rsp_data, rsp_flags);
    finish_rsp();
  endtask

  task automatic test_reset_in_wait();
    logic [111:0] outs;
    req_a = 32'h3F800000; req_b = 32'h40000000; req_op = 3'b000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    outs = {alu_a, alu_b, alu_op, rsp_data, rsp_flags, rsp_op, rsp_valid, req_ready};
    total++; if (outs !== '0) begin bad++; $display("FAIL rstwait_async got=%h exp=0", outs); end
    @(posedge clk); #1;
    outs = {alu_a, alu_b, alu_op, rsp_data, rsp_flags, rsp_op, rsp_valid, req_ready};
    total++; if (outs !== '0) begin bad++; $display("FAIL rstwait_held got=%h exp=0", outs); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL rstwait_after cyc=%0d got=%b exp=01", i, {rsp_valid, req_ready}); end
    end
    $display("reset in wait done");
  endtask

  typedef struct {
    logic [36:0] exp;
    logic [2:0]  op;
    int          acc_edge;
  } entry_t;

  task automatic test_random();
    localparam int N = 60;
    logic [31:0] ga [N];
    logic [31:0] gb [N];
    logic [2:0]  gop [N];
    logic [31:0] specials [6];
    entry_t q[$];
    entry_t e;
    int cyc, idx, n_done;
    bit front_seen, acc, rh;
    specials[0] = 32'h7F800000; specials[1] = 32'hFF800000; specials[2] = 32'h7FC00001;
    specials[3] = 32'h00000000; specials[4] = 32'h80000000; specials[5] = 32'h3F800000;
    for (int i = 0; i < N; i++) begin
      ga[i]  = ($urandom % 3 == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      gb[i]  = ($urandom % 3 == 0) ? 32'h0 : $urandom;
      gop[i] = ($urandom % 6 == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
    end
    cyc = 0; idx = 0; n_done = 0; front_seen = 0;
    req_a = ga[0]; req_b = gb[0]; req_op = gop[0]; req_valid = 1'b1;
    rsp_ready = ($urandom % 3) != 0;
    while ((idx < N || q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      rh  = rsp_valid && rsp_ready;
      acc = req_valid && req_ready;
      if (rh) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious_rsp data=%h exp=none", rsp_data);
        end else begin
          if ({rsp_flags, rsp_data, rsp_op} !== {q[0].exp, q[0].op}) begin
            bad++; $display("FAIL rnd_rsp n=%0d got=%b_%h_%b exp=%b_%h_%b", n_done, rsp_flags, rsp_data, rsp_op,
                            q[0].exp[36:32], q[0].exp[31:0], q[0].op);
          end
          $display("txn rnd %0d op=%b data=%h flags=%b", n_done, rsp_op, rsp_data, rsp_flags);
          void'(q.pop_front());
          front_seen = 0;
          n_done++;
        end
      end
      if (acc) begin
        e.exp = ref_rsp(ga[idx], gb[idx], gop[idx]);
        e.op = gop[idx];
        e.acc_edge = cyc + 1;
        q.push_back(e);
        idx++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rsp_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_valid_without_req cyc=%0d", cyc);
        end else if (!front_seen) begin
          front_seen = 1;
          if (cyc - q[0].acc_edge != (q[0].op[2] ? 0 : LAT)) begin
            bad++; $display("FAIL rnd_timing got=%0d exp=%0d", cyc - q[0].acc_edge, q[0].op[2] ? 0 : LAT);
          end
        end
      end
      if (idx < N) begin
        req_a = ga[idx]; req_b = gb[idx]; req_op = gop[idx]; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      rsp_ready = ($urandom % 3) != 0;
    end
    total++; if (n_done != N) begin bad++; $display("FAIL rnd_completed got=%0d exp=%0d", n_done, N); end
    rsp_ready = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_reserved();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter LATENCY, default 2, SHALL be the number of clk rising edges from alu_a/alu_b/alu_op being driven stable until alu_o is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  issuer accepts a request this cycle.
REQ-006 req_a  input  32  IEEE-754 single operand A.
REQ-007 req_b  input  32  IEEE-754 single operand B.
REQ-008 req_op  input  3  opcode: 000 ADD, 001 SUB, 010 DIV, 011 MUL, 1xx reserved.
REQ-009 alu_a  output  32  operand A to the ALU.
REQ-010 alu_b  output  32  operand B to the ALU.
REQ-011 alu_op  output  3  opcode to the ALU.
REQ-012 alu_o  input  32  ALU result.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_data  output  32  captured result.
REQ-016 rsp_flags  output  5  {err, nan, inf, zero, sign}.
REQ-017 rsp_op  output  3  opcode of the request that produced the response.

Function
REQ-018 States SHALL be IDLE, WAIT and DONE.
REQ-019 req_ready SHALL be 1 in IDLE, and in DONE when rsp_ready is 1; 0 otherwise.
REQ-020 Request handshake (req_valid & req_ready) SHALL register req_a/req_b/req_op into alu_a/alu_b/alu_op and clear the wait counter.
REQ-021 Legal opcode accepted: next state WAIT; reserved opcode (req_op[2]=1): next state DONE, ALU not waited on.
REQ-022 alu_a/alu_b/alu_op SHALL hold constant from acceptance until the next accepted request.
REQ-023 In WAIT the 4-bit counter SHALL increment each edge; on the edge where it equals LATENCY-1, alu_o SHALL be captured into rsp_data and state SHALL go to DONE.
REQ-024 End-to-end: rsp_valid SHALL rise exactly LATENCY+1 edges after the accepting edge when no backpressure.
REQ-025 rsp_valid SHALL be 1 only in DONE; rsp_data/rsp_flags/rsp_op SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-026 Response handshake with no new request: DONE -> IDLE. With a simultaneous request handshake: DONE -> WAIT (or DONE for reserved op), zero bubble.
REQ-027 Flags from captured word: nan = exp 0xFF and frac!=0; inf = exp 0xFF and frac==0; zero = exp 0 and frac==0; sign = bit 31; err = 0.
REQ-028 Reserved opcode response: rsp_data = 0x7FC00000, flags err=1, nan=1, others 0.
REQ-029 req_valid in WAIT SHALL be ignored (not accepted, not lost by the issuer; requester must hold it).
REQ-030 alu_o SHALL be sampled only on the capture edge; changes at other times SHALL not affect rsp_data.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, counter 0, alu_a=0, alu_b=0, alu_op=000, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_op=000, req_ready=0 while held.
REQ-032 Reset during WAIT or DONE SHALL discard the operation with no response emitted.
REQ-033 After rst_n deasserts, req_ready SHALL be 1 on the first edge-following cycle.

Structure
REQ-034 Shared package alu_pkg SHALL hold opcode constants, state encoding, canonical NaN 0x7FC00000 and flag bit indices.
REQ-035 One combinational sub-module fp_classify (32-bit in, nan/inf/zero/sign out) SHALL produce the flags.

Verification
REQ-036 ADD 0x3F800000 + 0x40000000, LATENCY=2 -> rsp_data 0x40400000, flags 00000, rsp_valid 3 edges after accept.
REQ-037 MUL 0x40400000 * 0xC0000000 -> rsp_data 0xC0C00000, flags 00001, rsp_op 011.
REQ-038 req_op 100, any operands -> rsp_data 0x7FC00000, flags 11000, rsp_valid one edge after accept.
REQ-039 rsp_ready held 0 for 5 cycles in DONE with ALU model changing alu_o -> rsp_data unchanged, req_ready 0 throughout.
REQ-040 Back-to-back: rsp_ready=1 and next req_valid=1 in DONE -> both handshakes same edge, second response LATENCY+1 edges later.
REQ-041 rst_n pulsed low in WAIT -> all outputs zero asynchronously, no rsp_valid afterward, req_ready 1 after release.
